mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the MIPS core, directly downstream of the general register file. It consumes the two read-port operands (rs on `data1`, rt on `data2`) for MULT, MULTU, DIV and DIVU and executes them over a fixed number of cycles. It holds the architectural HI/LO registers and raises `busy` so the pipeline can stall MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only when `busy`=0.
- `op`  in  3: operation, encoded as:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 110 and 111: no-op.
- `a`  in  WIDTH: rs operand (dividend or multiplicand); value for MTHI/MTLO.
- `b`  in  WIDTH: rt operand (divisor or multiplier).
- `busy`  out  1: an operation is in progress.
- `done`  out  1: one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- **States:** IDLE, CALC, FIX.
- **Accept:** a rising edge with `start`=1, `busy`=0 and `op` in 000–011:
  - latch the operand magnitudes (absolute values for signed ops), the signs and the op;
  - clear the iteration counter and go to CALC.
- **Operand isolation:** `a`, `b` and `op` are ignored after accept.
- **MTHI/MTLO:** at the accepting edge, write `a` into `hi`/`lo`. State stays IDLE; `busy` and `done` are not asserted.
- **No-op:** op 110/111 with `start`=1 is a no-op.
- **CALC:** one iteration per edge, WIDTH edges total.
  - Multiply: shift-add on the 2·WIDTH-bit accumulator.
  - Divide: restoring division, one quotient bit per edge.
  - After the last iteration go to FIX.
- **FIX:** one edge.
  - Apply sign correction.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- **Multiply result:** the full 2·WIDTH-bit product; `hi` gets the upper half, `lo` the lower half.
  - MULT: two's-complement signed.
  - MULTU: unsigned.
- **Divide result:** `lo` = quotient, `hi` = remainder.
  - Signed division truncates toward zero.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- **Divide by zero (b=0), DIV and DIVU:** `lo`=all ones, `hi`=`a` as latched (raw, not the magnitude). Same latency as a normal divide.
- **Signed overflow:** DIV of 0x8000_0000 by 0xFFFF_FFFF gives `lo`=0x8000_0000, `hi`=0.
- **Start while busy:** ignored, including MTHI/MTLO; no queueing.
- **Result visibility:** `hi`/`lo` keep their old values for the whole operation and change only at the FIX edge.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE.
- **Reset mid-operation:** any `rst_n` low, including mid-CALC, aborts immediately; no partial result is written.
- **Edge numbering:** let E0 be the accepting edge.
  - `busy` goes high after E0.
  - Iterations happen on E1..E_WIDTH.
  - FIX happens on E_WIDTH+1; with WIDTH=32 that is E33.
- **busy:** high for exactly WIDTH+1 cycles; it is the registered state != IDLE.
- **done:** high for exactly one cycle, after E_WIDTH+1, aligned with the new `hi`/`lo`. `busy` is already 0 in that cycle.
- **Back-to-back:** a new `start` may be accepted on the edge where `done` is high.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Structure
- Shared package `mdu_pkg` holds:
  - `op` encodings as named constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - the state encoding type.
- Single module with one FSM and a shared 2·WIDTH accumulator.
- No sub-module: multiply and divide share the counter and the accumulator register.

## Test plan
- **MULTU:** a=0xFFFF_FFFF, b=0xFFFF_FFFF
  - `busy` high 33 cycles;
  - then `done` pulse with `hi`=0xFFFF_FFFE, `lo`=0x0000_0001.
- **MULT:** a=-7 (0xFFFF_FFF9), b=3 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB.
- **DIV:** a=-7, b=2 → `lo`=0xFFFF_FFFD (-3), `hi`=0xFFFF_FFFF (-1).
- **DIVU:** a=2333, b=10 → `lo`=233, `hi`=3.
- **Divide by zero:** DIVU a=2333, b=0 → `lo`=0xFFFF_FFFF, `hi`=2333 after 33 cycles.
- **Busy-time writes and reset:**
  - Issue MTHI a=0x1234 during an active MULTU: ignored; `hi` unchanged until `done`.
  - Then issue MTLO a=5 while idle: `lo`=5 next cycle, no `done`.
  - Pull `rst_n` low at iteration 10 of a DIV: `busy`, `hi`, `lo` all 0 immediately, and no `done` follows.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings and FSM state type for the multiply/divide unit
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative MIPS multiply/divide unit holding HI/LO
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed, op_is_div, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        neg_a     = op_signed && a[WIDTH-1];
        neg_b     = op_signed && b[WIDTH-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;

        // Multiply: the multiplier sits in the low half and shifts out as the
        // partial product (with its carry) shifts in from the top.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
        // Divide: remainder is the upper half; shifting left can carry one bit,
        // so the trial subtract is one bit wider than the divisor.
        div_part  = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_part - {1'b0, opb_q};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op[2] == 1'b0) begin
                        state_d    = ST_CALC;
                        cnt_d      = '0;
                        acc_d      = {{WIDTH{1'b0}}, mag_a};
                        opb_d      = mag_b;
                        raw_a_d    = a;
                        is_div_d   = op_is_div;
                        neg_res_d  = neg_a ^ neg_b;
                        neg_rem_d  = neg_a;
                        div_zero_d = (b == '0);
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (div_part >= {1'b0, opb_q}) begin
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                if (cnt_q == LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic reference model
module tb_mdu;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int compared = 0;
    int mismatched = 0;

    mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: HI/LO straight from integer arithmetic on 64-bit values.
    task automatic ref_model(input logic [2:0] rop, input logic [W-1:0] ra, input logic [W-1:0] rb,
                             output logic [W-1:0] rhi, output logic [W-1:0] rlo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        rhi = '0;
        rlo = '0;
        case (rop)
            OP_MULT: begin
                p = 64'(sa * sb);
                rhi = p[63:32]; rlo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, ra} * {32'b0, rb};
                rhi = p[63:32]; rlo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (rb == 0) begin
                    rhi = ra; rlo = '1;
                end else if (rop == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    rhi = r[31:0]; rlo = q[31:0];
                end else begin
                    rhi = ra % rb; rlo = ra / rb;
                end
            end
            default: ;
        endcase
    endtask

    // Issues one op; returns result at the done cycle, busy cycle count and done position.
    task automatic do_op(input logic [2:0] dop, input logic [W-1:0] da, input logic [W-1:0] db,
                         input bit no_wait,
                         output logic [W-1:0] ohi, output logic [W-1:0] olo,
                         output int busy_cyc, output int done_at);
        if (!no_wait) @(negedge clk);
        start = 1'b1; op = dop; a = da; b = db;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        busy_cyc = 0; done_at = 0; ohi = 'x; olo = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_at = k; ohi = hi; olo = lo;
                break;
            end
        end
    endtask

    task automatic write_reg(input logic [2:0] wop, input logic [W-1:0] wval);
        @(negedge clk);
        start = 1'b1; op = wop; a = wval;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            mismatched++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]   tops [5] = '{OP_MULTU, OP_MULT, OP_DIV, OP_DIVU, OP_DIVU};
        logic [W-1:0] tas  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd2333, 32'd2333};
        logic [W-1:0] tbs  [5] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd10, 32'd0};
        logic [W-1:0] ehi  [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd2333};
        logic [W-1:0] elo  [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd233, 32'hFFFF_FFFF};
        logic [W-1:0] rhi, rlo;
        int bc, da;
        for (int i = 0; i < 5; i++) begin
            do_op(tops[i], tas[i], tbs[i], 1'b0, rhi, rlo, bc, da);
            compared++;
            if (rhi !== ehi[i] || rlo !== elo[i] || bc != 33 || da != 34) begin
                mismatched++;
                $display("FAIL directed[%0d]: hi=%h lo=%h busy_cycles=%0d done_at=%0d required %h %h 33 34",
                         i, rhi, rlo, bc, da, ehi[i], elo[i]);
            end
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_pulse_width: done=%b required 0", done);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] rhi, rlo;
        int bc, da;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rhi, rlo, bc, da);
        compared++;
        if (rhi !== 32'h0 || rlo !== 32'h8000_0000 || da != 34) begin
            mismatched++;
            $display("FAIL div_overflow: hi=%h lo=%h done_at=%0d required 00000000 80000000 34", rhi, rlo, da);
        end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, rhi, rlo, bc, da);
        compared++;
        if (rhi !== 32'hFFFF_FFF9 || rlo !== 32'hFFFF_FFFF || da != 34) begin
            mismatched++;
            $display("FAIL div_signed_by_zero: hi=%h lo=%h done_at=%0d required fffffff9 ffffffff 34", rhi, rlo, da);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] specials [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
        logic [W-1:0] ra, rb, rhi, rlo, ehi, elo;
        logic [2:0]   rop;
        int bc, da;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 100));
            ref_model(rop, ra, rb, ehi, elo);
            do_op(rop, ra, rb, 1'b0, rhi, rlo, bc, da);
            compared++;
            if (rhi !== ehi || rlo !== elo || bc != 33 || da != 34) begin
                mismatched++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h busy=%0d done_at=%0d required %h %h 33 34",
                         i, rop, ra, rb, rhi, rlo, bc, da, ehi, elo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] rhi, rlo, ehi, elo;
        int bc, da;
        do_op(OP_MULTU, 32'd1000, 32'd1000, 1'b0, rhi, rlo, bc, da);
        do_op(OP_DIVU, 32'd100, 32'd7, 1'b1, rhi, rlo, bc, da);
        ref_model(OP_DIVU, 32'd100, 32'd7, ehi, elo);
        compared++;
        if (rhi !== ehi || rlo !== elo || da != 34) begin
            mismatched++;
            $display("FAIL back_to_back: hi=%h lo=%h done_at=%0d required %h %h 34", rhi, rlo, da, ehi, elo);
        end
    endtask

    task automatic test_busy_writes();
        bit hi_moved = 0;
        bit seen_done = 0;
        write_reg(OP_MTHI, 32'h0000_AAAA);
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin seen_done = 1; break; end
            if (hi !== 32'h0000_AAAA) hi_moved = 1;
        end
        compared++;
        if (hi_moved || !seen_done || hi !== 32'hFFFF_FFFE) begin
            mismatched++;
            $display("FAIL mthi_while_busy: moved=%0d done=%0d hi=%h required 0 1 fffffffe", hi_moved, seen_done, hi);
        end
        write_reg(OP_MTLO, 32'd5);
        compared++;
        if (lo !== 32'd5 || done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mtlo_idle: lo=%h done=%b busy=%b required 00000005 0 0", lo, done, busy);
        end
        write_reg(3'b110, 32'hDEAD_BEEF);
        compared++;
        if (lo !== 32'd5 || hi !== 32'hFFFF_FFFE || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL noop: hi=%h lo=%h busy=%b done=%b required fffffffe 00000005 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_reset_mid();
        bit done_seen = 0;
        bit busy_seen = 0;
        write_reg(OP_MTLO, 32'h7777);
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_seen = 1;
            if (busy) busy_seen = 1;
        end
        compared++;
        if (done_seen || busy_seen || hi !== '0 || lo !== '0) begin
            mismatched++;
            $display("FAIL after_reset_abort: done_seen=%0d busy_seen=%0d hi=%h lo=%h required 0 0 0 0",
                     done_seen, busy_seen, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_random();
        test_back_to_back();
        test_busy_writes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
